// File: rtl/fetch_sequencer_pkg.sv
// Shared bus definitions for the 4-bit multiplexed instruction bus:
// subcycle encoding and the opcode groups that trigger a command strobe.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } subcycle_t;

    localparam logic [3:0]  SRC_OPR_DEF  = 4'h2;
    localparam logic [3:0]  IO_OPR_DEF   = 4'hE;
    localparam logic [11:0] RESET_PC_DEF = 12'h000;

endpackage

// File: rtl/bus_cycle_counter.sv
// Eight-subcycle frame counter with halt, also used by the ROM/RAM chips
// so that every device on the bus agrees on the current subcycle.
module bus_cycle_counter
    import fetch_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    output subcycle_t  cycle,
    output logic [7:0] strobe
);

    subcycle_t next_cycle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle <= A1;
        end else begin
            cycle <= next_cycle;
        end
    end

    // Natural 3-bit wrap takes X3 back to A1.
    always_comb begin
        next_cycle = cycle;
        if (!halt) begin
            next_cycle = subcycle_t'(cycle + 3'd1);
        end
        strobe = 8'b1 << cycle;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Bus master for the multiplexed instruction bus: sends the PC as nibbles,
// captures OPR/OPA, hands the byte to execute and handles jumps and halt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [11:0] RESET_PC = RESET_PC_DEF,
    parameter logic [3:0]  SRC_OPR  = SRC_OPR_DEF,
    parameter logic [3:0]  IO_OPR   = IO_OPR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic        sync,
    output logic        cmd,
    input  logic [3:0]  src_chip,
    input  logic        jump_valid,
    input  logic [11:0] jump_addr,
    output logic        jump_ack,
    output logic        inst_valid,
    output logic [7:0]  inst,
    output logic [11:0] inst_pc
);

    subcycle_t  cycle;
    logic [7:0] strobe;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        src_cmd;

    bus_cycle_counter u_counter (
        .clock  (clock),
        .reset  (reset),
        .halt   (halt),
        .cycle  (cycle),
        .strobe (strobe)
    );

    // inst_pc is latched with OPA so it stays tied to the byte even after pc moves on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            opr     <= 4'h0;
            opa     <= 4'h0;
            inst_pc <= 12'h000;
        end else if (!halt) begin
            if (strobe[M1]) begin
                opr <= data_i;
            end
            if (strobe[M2]) begin
                opa     <= data_i;
                inst_pc <= pc;
            end
            if (strobe[X3]) begin
                pc <= jump_valid ? jump_addr : pc + 12'd1;
            end
        end
    end

    // Bus drive and command decode; reset forces the bus idle immediately.
    always_comb begin
        data_o  = 4'h0;
        data_en = 1'b0;
        cmd     = 1'b1;
        src_cmd = (opr == SRC_OPR) && opa[0];
        if (!reset) begin
            if (strobe[A1]) begin
                data_o  = pc[3:0];
                data_en = 1'b1;
            end else if (strobe[A2]) begin
                data_o  = pc[7:4];
                data_en = 1'b1;
            end else if (strobe[A3]) begin
                data_o  = pc[11:8];
                data_en = 1'b1;
            end else if (strobe[X2] && src_cmd) begin
                data_o  = src_chip;
                data_en = 1'b1;
                cmd     = 1'b0;
            end else if (strobe[M2] && (opr == IO_OPR)) begin
                cmd     = 1'b0;
            end
        end
        sync       = (cycle == X3);
        inst_valid = strobe[X1] && !halt && !reset;
        jump_ack   = strobe[X3] && !halt && jump_valid && !reset;
        inst       = {opr, opa};
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a simple ROM model drives the
// returned byte on M1/M2 and each step is compared with hand-worked values.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        halt;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_en;
    logic        sync;
    logic        cmd;
    logic [3:0]  src_chip;
    logic        jump_valid;
    logic [11:0] jump_addr;
    logic        jump_ack;
    logic        inst_valid;
    logic [7:0]  inst;
    logic [11:0] inst_pc;

    int passCount;
    int checkCount;

    logic [3:0]  lastDataO;
    logic        lastEn, lastCmd, lastSync, lastValid, lastAck;
    logic [7:0]  lastInst;
    logic [11:0] lastInstPc;

    logic [3:0]  frDataO [8];
    logic [7:0]  frEn, frCmd, frSync, frValid, frAck;
    logic [7:0]  frInst;
    logic [11:0] frInstPc;

    logic [19:0] haltNibbles;
    logic [4:0]  haltEnables;
    logic        haltPulses;

    fetch_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .halt       (halt),
        .data_i     (data_i),
        .data_o     (data_o),
        .data_en    (data_en),
        .sync       (sync),
        .cmd        (cmd),
        .src_chip   (src_chip),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .jump_ack   (jump_ack),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // One subcycle: drive the bus nibble, sample outputs mid-cycle, then step past the edge.
    task automatic applyStimulus(input logic [3:0] nibble);
        data_i = nibble;
        #1;
        lastDataO  = data_o;
        lastEn     = data_en;
        lastCmd    = cmd;
        lastSync   = sync;
        lastValid  = inst_valid;
        lastAck    = jump_ack;
        lastInst   = inst;
        lastInstPc = inst_pc;
        @(posedge clock);
        #1;
        if (lastAck) jump_valid = 1'b0;
    endtask

    task automatic runFrame(input logic [7:0] romByte, input int jumpAt, input logic [11:0] addr);
        for (int k = 0; k < 8; k++) begin
            if (k == jumpAt) begin
                jump_valid = 1'b1;
                jump_addr  = addr;
            end
            applyStimulus(k == 3 ? romByte[7:4] : (k == 4 ? romByte[3:0] : 4'h0));
            frDataO[k] = lastDataO;
            frEn[k]    = lastEn;
            frCmd[k]   = lastCmd;
            frSync[k]  = lastSync;
            frValid[k] = lastValid;
            frAck[k]   = lastAck;
            if (k == 5) begin
                frInst   = lastInst;
                frInstPc = lastInstPc;
            end
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        halt       = 1'b0;
        data_i     = 4'h0;
        src_chip   = 4'h0;
        jump_valid = 1'b0;
        jump_addr  = 12'h000;

        #2;
        checkOutput("reset_data_en", 32'(data_en), 32'h0);
        checkOutput("reset_data_o", 32'(data_o), 32'h0);
        checkOutput("reset_cmd", 32'(cmd), 32'h1);
        checkOutput("reset_sync", 32'(sync), 32'h0);
        checkOutput("reset_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("reset_inst", 32'(inst), 32'h0);
        checkOutput("reset_inst_pc", 32'(inst_pc), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // First fetch from RESET_PC
        runFrame(8'hD5, -1, 12'h000);
        checkOutput("f0_addr_nibbles", 32'({frDataO[2], frDataO[1], frDataO[0]}), 32'h000);
        checkOutput("f0_data_en", 32'(frEn), 32'h07);
        checkOutput("f0_sync", 32'(frSync), 32'h80);
        checkOutput("f0_inst_valid", 32'(frValid), 32'h20);
        checkOutput("f0_inst", 32'(frInst), 32'hD5);
        checkOutput("f0_inst_pc", 32'(frInstPc), 32'h000);
        checkOutput("f0_cmd", 32'(frCmd), 32'hFF);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("f1_addr_nibbles", 32'({frDataO[2], frDataO[1], frDataO[0]}), 32'h001);

        // Preload FFE via a jump, then walk across the wrap
        runFrame(8'h00, 0, 12'hFFE);
        checkOutput("preload_ack", 32'(frAck), 32'h80);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("wrap0_inst_pc", 32'(frInstPc), 32'hFFE);
        checkOutput("wrap0_a3", 32'(frDataO[2]), 32'hF);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("wrap1_inst_pc", 32'(frInstPc), 32'hFFF);
        checkOutput("wrap1_a3", 32'(frDataO[2]), 32'hF);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("wrap2_inst_pc", 32'(frInstPc), 32'h000);
        checkOutput("wrap2_a3", 32'(frDataO[2]), 32'h0);
        checkOutput("wrap2_ack", 32'(frAck), 32'h00);

        // SRC with OPA[0]=1 drives chip id in X2, OPA[0]=0 does not
        src_chip = 4'h3;
        runFrame(8'h21, -1, 12'h000);
        checkOutput("src_cmd", 32'(frCmd), 32'hBF);
        checkOutput("src_data_o_x2", 32'(frDataO[6]), 32'h3);
        checkOutput("src_data_en", 32'(frEn), 32'h47);
        checkOutput("src_inst", 32'(frInst), 32'h21);
        runFrame(8'h20, -1, 12'h000);
        checkOutput("nosrc_cmd", 32'(frCmd), 32'hFF);
        checkOutput("nosrc_data_en", 32'(frEn), 32'h07);

        // I/O group strobes cmd only in M2
        runFrame(8'hE2, -1, 12'h000);
        checkOutput("io_cmd", 32'(frCmd), 32'hEF);
        checkOutput("io_data_en", 32'(frEn), 32'h07);
        checkOutput("io_inst_pc", 32'(frInstPc), 32'h003);

        // Jump raised at M1 lands at X3
        runFrame(8'h00, 3, 12'h4A7);
        checkOutput("jump_ack", 32'(frAck), 32'h80);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("jump_addr_nibbles", 32'({frDataO[2], frDataO[1], frDataO[0]}), 32'h4A7);
        checkOutput("jump_inst_pc", 32'(frInstPc), 32'h4A7);

        // Halt for 5 clocks in A2 with a jump already pending
        jump_valid = 1'b1;
        jump_addr  = 12'h123;
        applyStimulus(4'h0);
        checkOutput("halt_a1_nibble", 32'(lastDataO), 32'h8);
        halt        = 1'b1;
        haltNibbles = 20'h0;
        haltEnables = 5'h0;
        haltPulses  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'h0);
            haltNibbles = {haltNibbles[15:0], lastDataO};
            haltEnables[i] = lastEn;
            haltPulses = haltPulses | lastValid | lastAck;
        end
        halt = 1'b0;
        checkOutput("halt_frozen_a2", 32'(haltNibbles), 32'hAAAAA);
        checkOutput("halt_data_en", 32'(haltEnables), 32'h1F);
        checkOutput("halt_no_pulses", 32'(haltPulses), 32'h0);
        frValid = 8'h00;
        frAck   = 8'h00;
        for (int k = 1; k < 8; k++) begin
            applyStimulus(k == 3 ? 4'h5 : (k == 4 ? 4'hC : 4'h0));
            frValid[k] = lastValid;
            frAck[k]   = lastAck;
            if (k == 5) begin
                frInst   = lastInst;
                frInstPc = lastInstPc;
            end
        end
        checkOutput("halt_release_valid", 32'(frValid), 32'h20);
        checkOutput("halt_release_ack", 32'(frAck), 32'h80);
        checkOutput("halt_release_inst", 32'(frInst), 32'h5C);
        checkOutput("halt_release_inst_pc", 32'(frInstPc), 32'h4A8);
        runFrame(8'h00, -1, 12'h000);
        checkOutput("halt_jump_nibbles", 32'({frDataO[2], frDataO[1], frDataO[0]}), 32'h123);

        // Asynchronous reset in X1 of an SRC fetch
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k == 3 ? 4'h2 : (k == 4 ? 4'h1 : 4'h0));
        end
        checkOutput("pre_reset_valid", 32'(inst_valid), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_cmd", 32'(cmd), 32'h1);
        checkOutput("async_reset_data_en", 32'(data_en), 32'h0);
        checkOutput("async_reset_valid", 32'(inst_valid), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        runFrame(8'hD5, -1, 12'h000);
        checkOutput("restart_nibbles", 32'({frDataO[2], frDataO[1], frDataO[0]}), 32'h000);
        checkOutput("restart_valid", 32'(frValid), 32'h20);
        checkOutput("restart_inst", 32'(frInst), 32'hD5);
        checkOutput("restart_sync", 32'(frSync), 32'h80);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
